// File: rtl/delta_pkg.sv
// Shared types and sizing helpers for the delta sequencers.
package delta_pkg;

    typedef enum logic [3:0] {
        IDLE, RD_MINUS, RD_PLUS, SUB, MUL, ADD, WRITE, INC, DONE
    } state_t;

    localparam int DEF_LOOPS_READ  = 3;
    localparam int DEF_LOOPS_SUB   = 10;
    localparam int DEF_LOOPS_MUL   = 10;
    localparam int DEF_LOOPS_ADD   = 10;
    localparam int DEF_LOOPS_WRITE = 2;

    // Terminal loop count; a LOOPS value of 0 behaves like 1.
    function automatic int lim_of(input int loops);
        return (loops < 1) ? 0 : loops - 1;
    endfunction

    // Counter width able to hold the largest terminal count.
    function automatic int cnt_w(input int a, input int b, input int c,
                                 input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/delta_loop_cnt.sv
// Per-state loop counter: clears on every state change, counts up to the
// terminal value and holds there, flagging the last cycle of the state.
module delta_loop_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] limit,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (!last)
            cnt <= cnt + 1'b1;
    end

    assign last = (cnt == limit);

endmodule

// File: rtl/delta_nth_ctrl.sv
// N-neighbour regression delta sequencer. Define DELTA_NTH_CTRL_CLAMP_EN to
// clamp neighbour frame addresses at the utterance edges (edge replication).
module delta_nth_ctrl
    import delta_pkg::*;
#(
    parameter int N_WIN       = 2,
    parameter int CEP_NUM     = 13,
    parameter int FRAME_NUM   = 98,
    parameter int LOOPS_READ  = DEF_LOOPS_READ,
    parameter int LOOPS_SUB   = DEF_LOOPS_SUB,
    parameter int LOOPS_MUL   = DEF_LOOPS_MUL,
    parameter int LOOPS_ADD   = DEF_LOOPS_ADD,
    parameter int LOOPS_WRITE = DEF_LOOPS_WRITE
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [$clog2(N_WIN+1)-1:0]   cfg_win,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(N_WIN+1)-1:0]   k_idx,
    output logic                         sel_plus,
    output logic                         rd_en,
    output logic                         sub_en,
    output logic                         mul_en,
    output logic                         add_en,
    output logic                         acc_clr,
    output logic                         write_en,
    output logic                         sel_addr,
    output logic [$clog2(CEP_NUM)-1:0]   cep_idx,
    output logic [$clog2(FRAME_NUM)-1:0] frame_idx,
    output logic [$clog2(FRAME_NUM)-1:0] nb_frame_idx
);

    localparam int KW = $clog2(N_WIN+1);
    localparam int CW = $clog2(CEP_NUM);
    localparam int FW = $clog2(FRAME_NUM);
    localparam int LW = cnt_w(LOOPS_READ, LOOPS_SUB, LOOPS_MUL, LOOPS_ADD, LOOPS_WRITE);

    localparam logic [KW-1:0] WIN_MAX    = KW'(N_WIN);
    localparam logic [CW-1:0] CEP_LAST   = CW'(CEP_NUM - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_NUM - 1);

    state_t        state, state_n;
    logic [KW-1:0] win, win_n, k_n;
    logic [CW-1:0] cep_n;
    logic [FW-1:0] frame_n;
    logic [LW-1:0] limit;
    logic          last;

    function automatic logic [KW-1:0] sat_win(input logic [KW-1:0] w);
        if (w == '0)
            return KW'(1);
        if (w > WIN_MAX)
            return WIN_MAX;
        return w;
    endfunction

    // Widened signed arithmetic so frame-k below zero is seen before truncation.
    function automatic logic [FW-1:0] nb_addr(input logic [FW-1:0] f,
                                              input logic [KW-1:0] kk,
                                              input logic plus);
        logic signed [31:0] fs, ks, s;
        fs = $signed(32'(f));
        ks = $signed(32'(kk));
        s  = plus ? (fs + ks) : (fs - ks);
`ifdef DELTA_NTH_CTRL_CLAMP_EN
        if (s < 0)
            s = 0;
        else if (s > FRAME_NUM - 1)
            s = FRAME_NUM - 1;
`endif
        return FW'(s);
    endfunction

    always_comb begin
        limit = '0;
        case (state)
            RD_MINUS, RD_PLUS: limit = LW'(lim_of(LOOPS_READ));
            SUB:               limit = LW'(lim_of(LOOPS_SUB));
            MUL:               limit = LW'(lim_of(LOOPS_MUL));
            ADD:               limit = LW'(lim_of(LOOPS_ADD));
            WRITE:             limit = LW'(lim_of(LOOPS_WRITE));
            default:           limit = '0;
        endcase
    end

    delta_loop_cnt #(.W(LW)) u_loop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state_n != state),
        .limit (limit),
        .last  (last)
    );

    always_comb begin
        state_n = state;
        win_n   = win;
        k_n     = k_idx;
        cep_n   = cep_idx;
        frame_n = frame_idx;
        case (state)
            IDLE: if (start) begin
                state_n = RD_MINUS;
                win_n   = sat_win(cfg_win);
                k_n     = KW'(1);
                cep_n   = '0;
                frame_n = '0;
            end
            RD_MINUS: if (last) state_n = RD_PLUS;
            RD_PLUS:  if (last) state_n = SUB;
            SUB:      if (last) state_n = MUL;
            MUL:      if (last) state_n = ADD;
            ADD: if (last) begin
                if (k_idx < win) begin
                    k_n     = k_idx + 1'b1;
                    state_n = RD_MINUS;
                end else begin
                    state_n = WRITE;
                end
            end
            WRITE: if (last)
                state_n = (cep_idx == CEP_LAST && frame_idx == FRAME_LAST) ? DONE : INC;
            INC: begin
                k_n     = KW'(1);
                state_n = RD_MINUS;
                if (cep_idx == CEP_LAST) begin
                    cep_n   = '0;
                    frame_n = frame_idx + 1'b1;
                end else begin
                    cep_n = cep_idx + 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                k_n     = '0;
                cep_n   = '0;
                frame_n = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            win          <= '0;
            k_idx        <= '0;
            cep_idx      <= '0;
            frame_idx    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sel_plus     <= 1'b0;
            rd_en        <= 1'b0;
            sub_en       <= 1'b0;
            mul_en       <= 1'b0;
            add_en       <= 1'b0;
            acc_clr      <= 1'b0;
            write_en     <= 1'b0;
            sel_addr     <= 1'b0;
            nb_frame_idx <= '0;
        end else begin
            state        <= state_n;
            win          <= win_n;
            k_idx        <= k_n;
            cep_idx      <= cep_n;
            frame_idx    <= frame_n;
            busy         <= !(state_n inside {IDLE, DONE});
            done         <= (state_n == DONE);
            sel_plus     <= (state_n == RD_PLUS);
            rd_en        <= (state_n inside {RD_MINUS, RD_PLUS});
            sub_en       <= (state_n == SUB);
            mul_en       <= (state_n == MUL);
            add_en       <= (state_n == ADD);
            acc_clr      <= (state_n == RD_MINUS) && (k_n == KW'(1));
            write_en     <= (state_n == WRITE);
            sel_addr     <= (state_n inside {ADD, WRITE});
            nb_frame_idx <= nb_addr(frame_n, k_n, state_n == RD_PLUS);
        end
    end

endmodule
